// File: rtl/decoder_seq_if.sv
// decoder_seq_if: bus bundle for decoder_seq.
//   master : drives e, a, mode, start, len; observes y, busy, done
//   slave  : the decoder side (inputs e/a/mode/start/len, outputs y/busy/done)
// N and CNT_W must match the parameters of the decoder_seq instance.
interface decoder_seq_if #(
  parameter int N     = 2,
  parameter int CNT_W = 4
);
  logic               e;
  logic [N-1:0]       a;
  logic [1:0]         mode;
  logic               start;
  logic [CNT_W-1:0]   len;
  logic [(1<<N)-1:0]  y;
  logic               busy;
  logic               done;

  modport master (
    output e, a, mode, start, len,
    input  y, busy, done
  );

  modport slave (
    input  e, a, mode, start, len,
    output y, busy, done
  );
endinterface

// File: rtl/decoder_seq.sv
// decoder_seq: registered N-to-2^N one-hot decoder with timed PULSE and
// rotating SCAN operations.
// Ports:
//   clk  : single clock, all state changes on its rising edge
//   rst  : synchronous active-high reset
//   bus  : decoder_seq_if.slave
//            e     enable; low blanks y and aborts a running operation
//            a     select index
//            mode  00 DIRECT, 01 PULSE, 10 SCAN, 11 OFF
//            start launches PULSE/SCAN (sampled only in IDLE)
//            len   pulse length / dwell per scan position (0 behaves as 1)
//            y     registered one-hot (or zero) output
//            busy  high while PULSE or SCAN is active
//            done  one-cycle strobe on normal completion
module decoder_seq #(
  parameter int N     = 2,
  parameter int CNT_W = 4
) (
  input  logic          clk,
  input  logic          rst,
  decoder_seq_if.slave  bus
);

  localparam int W = 1 << N;
  localparam logic [N-1:0] LAST_POS = N'(W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    SCAN  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [W-1:0]      y_q, y_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  len_q, len_d;   // captured effective length L
  logic [CNT_W-1:0]  cnt_q, cnt_d;   // cycles the current position has been shown
  logic [N-1:0]      pos_q, pos_d;   // scan positions already completed

  logic [W-1:0]      dec_a;
  logic [CNT_W-1:0]  len_eff;
  logic              dwell_end;
  logic              launch;

  // One-hot decode of the live select index.
  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_dec
      assign dec_a[gi] = (bus.a == N'(gi));
    end
  endgenerate

  assign len_eff   = (bus.len == '0) ? CNT_W'(1) : bus.len;
  // cnt counts from 1 up to L, so L = 2^CNT_W-1 fits without wrapping.
  assign dwell_end = (cnt_q == len_q);
  assign launch    = bus.start && bus.e && (bus.mode == 2'b01 || bus.mode == 2'b10);

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    done_d  = 1'b0;
    len_d   = len_q;
    cnt_d   = cnt_q;
    pos_d   = pos_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        pos_d = '0;
        if (bus.mode == 2'b00) begin
          y_d = bus.e ? dec_a : '0;
        end else begin
          y_d = '0;
        end
        if (launch) begin
          // The operation's position lives in y_q from here on, so the
          // select index needs no separate capture register.
          state_d = (bus.mode == 2'b01) ? PULSE : SCAN;
          y_d     = dec_a;
          len_d   = len_eff;
          cnt_d   = CNT_W'(1);
        end
      end

      PULSE: begin
        if (!bus.e) begin
          state_d = IDLE;
          y_d     = '0;
        end else if (dwell_end) begin
          state_d = IDLE;
          y_d     = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      SCAN: begin
        if (!bus.e) begin
          state_d = IDLE;
          y_d     = '0;
        end else if (dwell_end) begin
          if (pos_q == LAST_POS) begin
            state_d = IDLE;
            y_d     = '0;
            done_d  = 1'b1;
          end else begin
            // Rotate left; the top bit wraps back to bit 0.
            y_d   = {y_q[W-2:0], y_q[W-1]};
            cnt_d = CNT_W'(1);
            pos_d = pos_q + N'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        y_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      y_q     <= '0;
      done_q  <= 1'b0;
      len_q   <= '0;
      cnt_q   <= '0;
      pos_q   <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      done_q  <= done_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
    end
  end

  assign bus.y    = y_q;
  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;

endmodule

// File: doc/decoder_seq.md
DECODER_SEQ -- requirements
Module: decoder_seq

Interface
REQ-001 The block SHALL have parameter N, default 2: select width; output width is 2^N; legal range 1..6.
REQ-002 The block SHALL have parameter CNT_W, default 4: width of the dwell/pulse length input and internal dwell counter.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port e, input, 1 bit: enable; low forces outputs off and aborts any operation.
REQ-006 The block SHALL have port a, input, N bits: select index.
REQ-007 The block SHALL have port mode, input, 2 bits: 00 DIRECT, 01 PULSE, 10 SCAN, 11 OFF.
REQ-008 The block SHALL have port start, input, 1 bit: launches a PULSE or SCAN operation.
REQ-009 The block SHALL have port len, input, CNT_W bits: pulse length (PULSE) or dwell per position (SCAN), in cycles.
REQ-010 The block SHALL have port y, output, 2^N bits: registered one-hot (or all-zero) decode output.
REQ-011 The block SHALL have port busy, output, 1 bit: high while a PULSE or SCAN operation is active.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle strobe on normal completion of PULSE or SCAN.

Function
REQ-013 The block SHALL implement FSM states IDLE, PULSE, SCAN; busy SHALL be 1 exactly when state is PULSE or SCAN.
REQ-014 In IDLE with mode=00: y SHALL equal (e ? 1<<a : 0) registered, 1-cycle latency; busy=0, done=0; start ignored.
REQ-015 In IDLE with mode=11: y SHALL be 0 next cycle; start ignored.
REQ-016 In IDLE with mode=01, start=1, e=1 sampled at edge T: a and len SHALL be captured; state->PULSE; y=1<<a from T+1.
REQ-017 Effective length L SHALL be len, with len=0 treated as 1.
REQ-018 PULSE: y SHALL hold 1<<a_captured for exactly L cycles (T+1..T+L); at T+L+1 y=0, done=1, busy=0, state IDLE.
REQ-019 In IDLE with mode=10, start=1, e=1 at edge T: a and len captured; state->SCAN; y=1<<a from T+1.
REQ-020 SCAN: each position SHALL be held L cycles, then y rotates left by one (bit 2^N-1 wraps to bit 0).
REQ-021 SCAN SHALL visit exactly 2^N positions (starting at a_captured), total 2^N*L cycles; next cycle y=0, done=1, state IDLE.
REQ-022 start, mode, a, len changes while busy SHALL be ignored; operation uses captured values only.
REQ-023 start with e=0, or mode in {00,11}, SHALL not launch an operation.
REQ-024 e=0 sampled while busy SHALL abort: next cycle y=0, busy=0, state IDLE, done=0.
REQ-025 In the done cycle (IDLE), a new start SHALL be accepted; y asserts the following cycle (one idle cycle of y=0 between operations).
REQ-026 done SHALL never be asserted for more than one consecutive cycle and never with busy=1.
REQ-027 y SHALL have at most one bit set in every cycle.
REQ-028 Dwell counter SHALL be CNT_W bits and never wrap; L=2^CNT_W-1 SHALL be supported exactly.

Reset
REQ-029 rst=1 at an edge SHALL set y=0, busy=0, done=0, state IDLE, counters and captured values to 0, overriding all other inputs.
REQ-030 rst mid-PULSE or mid-SCAN SHALL abort without done; first start after rst release SHALL be accepted normally.

Verification (N=2, CNT_W=4)
REQ-031 DIRECT: e=1, a=0..3 each cycle -> y=0001,0010,0100,1000 one cycle later; e=0 -> y=0000.
REQ-032 PULSE: mode=01, a=2, len=3, start 1 cycle -> y=0100 for 3 cycles, then y=0000 with done=1 for 1 cycle; len=0 -> 1-cycle pulse.
REQ-033 SCAN: mode=10, a=3, len=2 -> y=1000,1000,0001,0001,0010,0010,0100,0100, then 0000 with done=1.
REQ-034 Abort: SCAN running, drop e at 3rd cycle -> y=0000, busy=0 next cycle, done never asserted.
REQ-035 Busy ignore + back-to-back: start/a changes during PULSE have no effect; start in done cycle -> new pulse begins next cycle.
REQ-036 Reset: rst asserted mid-PULSE -> y=0000, busy=0, done=0 next cycle; after release DIRECT decode resumes correctly.
